// File: rtl/fpu_divider_if.sv
// Handshake bundle for the iterative single-precision divider.
// The master issues start/A/B; the slave returns busy/done/outp.
interface fpu_divider_if;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] outp;

  modport master (
    output start, A, B,
    input  busy, done, outp
  );

  modport slave (
    input  start, A, B,
    output busy, done, outp
  );
endinterface

// File: rtl/fpu_divider.sv
// Iterative IEEE 754 single-precision divider (outp = A / B).
// Restoring division, one quotient bit per clock, then one normalise/pack
// cycle. Truncating (round toward zero); denormal inputs and results are
// flushed to zero. Divide-by-zero gives signed infinity.
module fpu_divider (
  input  logic          clk,
  input  logic          rst_n,
  fpu_divider_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, NORM} state_t;

  state_t      state;
  logic        sign;
  logic [7:0]  exp_a;
  logic [7:0]  exp_b;
  logic [23:0] man_b;
  logic [25:0] rem;
  logic [24:0] quo;
  logic [4:0]  cnt;
  logic        special;
  logic        spec_inf;

  logic        rem_ge;
  logic [25:0] rem_sub;
  logic [25:0] rem_nxt;
  logic [24:0] quo_nxt;

  logic signed [9:0] exp_sum;
  logic [22:0]       frac;
  logic [31:0]       result;

  // One restoring-division step: compare, conditionally subtract, shift.
  always_comb begin
    rem_ge  = (rem >= {2'b00, man_b});
    rem_sub = rem_ge ? (rem - {2'b00, man_b}) : rem;
    rem_nxt = rem_sub << 1;
    quo_nxt = {quo[23:0], rem_ge};
  end

  // Normalise the quotient, apply exponent range limits and pack the word.
  always_comb begin
    exp_sum = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b})
            + (quo[24] ? 10'sd127 : 10'sd126);
    frac    = quo[24] ? quo[23:1] : quo[22:0];
    if (special) begin
      result = spec_inf ? {sign, 8'hFF, 23'h0} : {sign, 31'h0};
    end else if (exp_sum >= 10'sd255) begin
      result = {sign, 8'hFF, 23'h0};
    end else if (exp_sum <= 10'sd0) begin
      result = {sign, 31'h0};
    end else begin
      result = {sign, exp_sum[7:0], frac};
    end
  end

  // Control FSM with registered handshake outputs and datapath state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sign     <= 1'b0;
      exp_a    <= '0;
      exp_b    <= '0;
      man_b    <= '0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      special  <= 1'b0;
      spec_inf <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.outp <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sign     <= bus.A[31] ^ bus.B[31];
            exp_a    <= bus.A[30:23];
            exp_b    <= bus.B[30:23];
            man_b    <= {1'b1, bus.B[22:0]};
            rem      <= {2'b00, 1'b1, bus.A[22:0]};
            quo      <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            // Divide-by-zero takes priority over a zero dividend.
            spec_inf <= (bus.B[30:23] == 8'h00);
            special  <= (bus.B[30:23] == 8'h00) || (bus.A[30:23] == 8'h00);
            if ((bus.B[30:23] == 8'h00) || (bus.A[30:23] == 8'h00)) begin
              state <= NORM;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd24) begin
            state <= NORM;
          end
        end
        NORM: begin
          bus.outp <= result;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          special  <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_divider.sv
// Directed self-checking bench for fpu_divider: normal divides, special
// operands, range limits, handshake behaviour and asynchronous reset.
module tb_fpu_divider;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  fpu_divider_if bus ();

  fpu_divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request and follow it to done. glitch_at > 0 pulses start with
  // other operands at that cycle of the operation.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_out, input int exp_lat, input int glitch_at);
    int lat;
    int busy_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (lat < 100) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
      if (glitch_at > 0 && lat == glitch_at) begin
        bus.start = 1'b1;
        bus.A     = 32'h3F800000;
        bus.B     = 32'h40400000;
      end else if (glitch_at > 0 && lat == glitch_at + 1) begin
        bus.start = 1'b0;
      end
      if (bus.done) break;
    end
    check({tag, "_done"},    32'(bus.done), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"},    32'(busy_cnt), 32'(exp_lat));
    check({tag, "_outp"},    bus.outp, exp_out);
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_outp_hold"},  bus.outp, exp_out);
  endtask

  initial begin
    int d1;
    int d2;
    int seen;
    logic prev_done;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_outp", bus.outp, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op("div_6_2",     32'h40C00000, 32'h40000000, 32'h40400000, 26, 0);
    do_op("div_1_3",     32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 26, 0);
    do_op("div_m75_25",  32'hC0F00000, 32'h40200000, 32'hC0400000, 26, 0);
    do_op("div_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 1, 0);
    do_op("neg_by_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 1, 0);
    do_op("zero_div",    32'h00000000, 32'h40A00000, 32'h00000000, 1, 0);
    do_op("zero_zero",   32'h00000000, 32'h00000000, 32'h7F800000, 1, 0);
    do_op("overflow",    32'h7F000000, 32'h00800000, 32'h7F800000, 26, 0);
    do_op("underflow",   32'h00800000, 32'h7F000000, 32'h00000000, 26, 0);
    do_op("start_ignored", 32'h40C00000, 32'h40000000, 32'h40400000, 26, 5);

    // Back-to-back: start held high, two results 27 clocks apart.
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 32'hC0F00000;
    bus.B     = 32'h40200000;
    d1 = -1;
    d2 = -1;
    prev_done = 1'b0;
    seen = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk);
      #1;
      if (bus.done && prev_done) seen++;
      prev_done = bus.done;
      if (bus.done) begin
        if (d1 < 0) begin
          d1 = i;
          check("b2b_outp1", bus.outp, 32'hC0400000);
        end else begin
          d2 = i;
          check("b2b_outp2", bus.outp, 32'hC0400000);
          bus.start = 1'b0;
          break;
        end
      end
    end
    bus.start = 1'b0;
    check("b2b_first_lat", 32'(d1), 32'd26);
    check("b2b_spacing",   32'(d2 - d1), 32'd27);
    check("b2b_single_pulse", 32'(seen), 32'd0);
    repeat (2) @(posedge clk);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 32'h40C00000;
    bus.B     = 32'h40000000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_done", 32'(bus.done), 32'd0);
    check("midreset_outp", bus.outp, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) seen++;
    end
    check("midreset_no_done", 32'(seen), 32'd0);
    do_op("after_reset", 32'h40C00000, 32'h40000000, 32'h40400000, 26, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpu_divider.md
# fpu_divider

Iterative IEEE 754 single-precision divider computing `outp = A / B` with a start/done handshake. It fills the division slot of the FPU's add/sub/mul datapath as a separate multi-cycle unit. It uses restoring division, one quotient bit per clock, followed by a single normalisation/pack cycle. Results are truncated (round toward zero) and denormals are flushed to zero.

## Interface
- Parameters: none; the format is fixed at 1 sign bit, 8 exponent bits (bias 127), and 23 fraction bits.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only while `busy`=0.
- `A`  in  32  dividend; captured on the accepting edge.
- `B`  in  32  divisor; captured on the accepting edge.
- `busy`  out  1  high from the accepting edge until the result edge.
- `done`  out  1  one-cycle pulse; `outp` is valid from this cycle on.
- `outp`  out  32  quotient; holds its value until the next result edge.

## Operation
- States:
  - IDLE: waits for `start`.
  - CALC: iterative division.
  - NORM: normalise, pack, and drive `done`.
- IDLE with `start`=1:
  - Capture the sign (`A[31]^B[31]`), both exponents, and both mantissas `{1,frac}`.
  - Set `busy`=1 and clear the iteration counter to 0.
  - If a special case applies, go to NORM with the special flag set. Otherwise go to CALC.
- Special cases are decided at accept time, in this priority order:
  1. B exponent = 0 (zero or denormal): result is signed infinity, `{sign,8'hFF,23'h0}`.
  2. A exponent = 0: result is signed zero, `{sign,31'h0}`.
- Exponent-255 inputs (inf/NaN) are unsupported and produce a don't-care result, with the same timing as a normal divide.
- CALC, restoring division:
  - The remainder R is 26 bits, initialised to the A mantissa. The divisor D is the B mantissa.
  - Each cycle: if R ≥ D then the quotient bit is 1 and R ← R−D; otherwise the bit is 0.
  - Then R ← R<<1 and the bit is shifted into the LSB of the 25-bit quotient Q.
  - The counter runs 0..24; after the iteration with counter = 24, go to NORM.
  - Q[24] carries weight 2^0.
- NORM, normal path:
  - If Q[24]=1: fraction = Q[23:1] and E = eA − eB + 127.
  - Else (Q[23] is guaranteed 1): fraction = Q[22:0] and E = eA − eB + 126.
- Exponent arithmetic uses 10-bit signed values:
  - E ≥ 255: signed infinity.
  - E ≤ 0: signed zero.
  - Otherwise: `{sign, E[7:0], fraction}`.
- NORM register updates: `outp` is loaded, `done`=1, `busy`=0, and the state returns to IDLE.
- `start` while `busy`=1 is ignored, and A/B changes during an operation have no effect.
- `start` held high in the NORM cycle's successor is accepted normally (back-to-back operation).

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - `busy`=0, `done`=0, `outp`=32'h0.
  - Counter, R, and Q are cleared.
  - Any in-flight operation is discarded and no `done` is produced for it.
- Normal divide, with edge 0 as the accepting edge:
  - Edges 1..25 perform the 25 iterations.
  - Edge 26 is NORM: `done`=1 and `outp` is valid in the cycle after edge 26.
  - Latency is 26 clocks from the accepting edge to `done`.
- Special case: the accepting edge goes to NORM, and edge 1 writes `outp` and drives `done`=1. Latency is 1 clock.
- `done` is high for exactly one cycle per accepted request.
- `busy` is high in the cycles after edges 0..25 (normal path) or after edge 0 only (special path).
- Maximum throughput is one result per 27 clocks when `start` is held high continuously.

## Test plan
- 6.0/2.0: A=0x40C00000, B=0x40000000 → `outp`=0x40400000, `done` 26 clocks after accept, `busy` high for exactly 26 cycles.
- 1.0/3.0: A=0x3F800000, B=0x40400000 → 0x3EAAAAAA (truncated, not 0x3EAAAAAB). Also −7.5/2.5: A=0xC0F00000, B=0x40200000 → 0xC0400000.
- Specials, 1-clock latency:
  - 0x3F800000/0x00000000 → 0x7F800000.
  - 0xBF800000/0x00000000 → 0xFF800000.
  - 0x00000000/0x40A00000 → 0x00000000.
  - 0x00000000/0x00000000 → 0x7F800000 (divide-by-zero wins).
- Range limits: 0x7F000000/0x00800000 → 0x7F800000 (overflow); 0x00800000/0x7F000000 → 0x00000000 (underflow).
- Handshake:
  - Pulse `start` with new operands mid-CALC: the pulse is ignored and the original result is returned.
  - Hold `start` high: back-to-back results, each `done` a single-cycle pulse, 27 clocks apart.
- Reset: assert `rst_n`=0 at iteration 10, asynchronously between edges → outputs zero immediately, no `done` appears. After release, a new 6.0/2.0 request completes correctly.
